// File: rtl/mem_sort_param_if.sv
// Host-side bus of the parametrised in-place memory sorter: load/read port,
// sort command and status. The sorter connects through the slave modport,
// the host (or a testbench) through the master modport.
interface mem_sort_param_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = 2 * ADDR_W;

  logic              start_sort;
  logic              descend;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [WIDTH-1:0]  rd_data;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  swap_count;

  modport master (
    output start_sort, descend, wr_en, wr_addr, wr_data, rd_addr,
    input  rd_data, busy, done, swap_count
  );

  modport slave (
    input  start_sort, descend, wr_en, wr_addr, wr_data, rd_addr,
    output rd_data, busy, done, swap_count
  );
endinterface

// File: rtl/mem_sort_param.sv
// Parametrised in-place bubble sorter over a DEPTH x WIDTH register file.
// The host loads words while idle, pulses start_sort and waits for done.
// One compare (and possible swap) of neighbouring words per clock.
// Optional feature: define MEM_SORT_EARLY_EXIT_EN to finish as soon as a
// whole pass completes without any swap.
module mem_sort_param #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic rst,
  mem_sort_param_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = 2 * ADDR_W;

  typedef enum logic [1:0] {IDLE, CMP, PASS_END, DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] j_q, j_d;
  logic [ADDR_W-1:0] pass_q, pass_d;
  logic              dir_q, dir_d;
  logic              swapped_q, swapped_d;
  logic [CNT_W-1:0]  swapCnt_q, swapCnt_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];

  logic              busyInt;
  logic              wrInRange;
  logic              rdInRange;
  logic              wrFire;
  logic [ADDR_W-1:0] jNext;
  logic [ADDR_W-1:0] lastJ;
  logic [WIDTH-1:0]  wordA;
  logic [WIDTH-1:0]  wordB;
  logic              outOfOrder;

  // With a power-of-two depth every address is valid, so no compare is built.
  if (DEPTH == (1 << ADDR_W)) begin : g_pow2
    assign wrInRange = 1'b1;
    assign rdInRange = 1'b1;
  end else begin : g_npow2
    assign wrInRange = (32'(bus.wr_addr) < DEPTH);
    assign rdInRange = (32'(bus.rd_addr) < DEPTH);
  end

  assign busyInt    = (state_q == CMP) || (state_q == PASS_END);
  assign wrFire     = bus.wr_en && !busyInt && wrInRange;
  assign jNext      = j_q + ADDR_W'(1);
  assign lastJ      = ADDR_W'(DEPTH - 2) - pass_q;
  assign wordA      = mem_q[j_q];
  assign wordB      = mem_q[jNext];
  assign outOfOrder = dir_q ? (wordA < wordB) : (wordA > wordB);

  assign bus.busy       = busyInt;
  assign bus.done       = (state_q == DONE);
  assign bus.swap_count = swapCnt_q;
  assign bus.rd_data    = rdInRange ? mem_q[bus.rd_addr] : '0;

  // Next-state logic: host writes while not busy, one compare/swap per CMP cycle.
  always_comb begin
    state_d   = state_q;
    j_d       = j_q;
    pass_d    = pass_q;
    dir_d     = dir_q;
    swapped_d = swapped_q;
    swapCnt_d = swapCnt_q;
    mem_d     = mem_q;

    if (wrFire) begin
      mem_d[bus.wr_addr] = bus.wr_data;
    end

    case (state_q)
      IDLE: begin
        if (bus.start_sort) begin
          state_d   = CMP;
          dir_d     = bus.descend;
          pass_d    = '0;
          j_d       = '0;
          swapCnt_d = '0;
          swapped_d = 1'b0;
        end
      end
      CMP: begin
        if (outOfOrder) begin
          mem_d[j_q]   = wordB;
          mem_d[jNext] = wordA;
          swapCnt_d    = swapCnt_q + CNT_W'(1);
          swapped_d    = 1'b1;
        end
        if (j_q == lastJ) begin
          state_d = PASS_END;
        end else begin
          j_d = jNext;
        end
      end
      PASS_END: begin
        j_d       = '0;
        pass_d    = pass_q + ADDR_W'(1);
        swapped_d = 1'b0;
        if (pass_q == ADDR_W'(DEPTH - 2)) begin
          state_d = DONE;
`ifdef MEM_SORT_EARLY_EXIT_EN
        end else if (!swapped_q) begin
          state_d = DONE;
`endif
        end else begin
          state_d = CMP;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and memory; reset clears everything including the words.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      j_q       <= '0;
      pass_q    <= '0;
      dir_q     <= 1'b0;
      swapped_q <= 1'b0;
      swapCnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      j_q       <= j_d;
      pass_q    <= pass_d;
      dir_q     <= dir_d;
      swapped_q <= swapped_d;
      swapCnt_q <= swapCnt_d;
      mem_q     <= mem_d;
    end
  end
endmodule

// File: tb/tb_mem_sort_param.sv
// Directed bench for mem_sort_param: a DEPTH=4 and a DEPTH=16 instance share
// one clock. Expected latencies follow MEM_SORT_EARLY_EXIT_EN when defined.
module tb_mem_sort_param;
  logic clk;
  logic rst4;
  logic rst16;
  int total = 0;
  int bad   = 0;

`ifdef MEM_SORT_EARLY_EXIT_EN
  localparam int EXP_SORTED_EDGES = 4;
  localparam int EXP_PREWR_EDGES  = 7;
`else
  localparam int EXP_SORTED_EDGES = 9;
  localparam int EXP_PREWR_EDGES  = 9;
`endif

  mem_sort_param_if #(.WIDTH(8), .DEPTH(4))  bus4  ();
  mem_sort_param_if #(.WIDTH(8), .DEPTH(16)) bus16 ();

  mem_sort_param #(.WIDTH(8), .DEPTH(4)) dut4 (
    .clk (clk),
    .rst (rst4),
    .bus (bus4.slave)
  );

  mem_sort_param #(.WIDTH(8), .DEPTH(16)) dut16 (
    .clk (clk),
    .rst (rst16),
    .bus (bus16.slave)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idleInputs();
    bus4.start_sort  = 1'b0;
    bus4.descend     = 1'b0;
    bus4.wr_en       = 1'b0;
    bus4.wr_addr     = '0;
    bus4.wr_data     = '0;
    bus4.rd_addr     = '0;
    bus16.start_sort = 1'b0;
    bus16.descend    = 1'b0;
    bus16.wr_en      = 1'b0;
    bus16.wr_addr    = '0;
    bus16.wr_data    = '0;
    bus16.rd_addr    = '0;
  endtask

  task automatic load4(input logic [7:0] w0, input logic [7:0] w1,
                       input logic [7:0] w2, input logic [7:0] w3);
    logic [7:0] w [4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus4.wr_en   = 1'b1;
      bus4.wr_addr = 2'(i);
      bus4.wr_data = w[i];
    end
    @(negedge clk);
    bus4.wr_en = 1'b0;
  endtask

  task automatic read4(input int a, output logic [7:0] d);
    bus4.rd_addr = 2'(a);
    #1;
    d = bus4.rd_data;
  endtask

  task automatic read16(input int a, output logic [7:0] d);
    bus16.rd_addr = 4'(a);
    #1;
    d = bus16.rd_data;
  endtask

  // Runs one DEPTH=4 sort; edges counts clock edges after the accepting edge
  // until done is seen, dones counts done-high cycles including 12 after it.
  task automatic sort4(input logic desc, input bit toggleDir, input int injectAt,
                       input bit preWrite, output int edges, output int dones,
                       output logic busyAtK);
    @(negedge clk);
    bus4.start_sort = 1'b1;
    bus4.descend    = desc;
    if (preWrite) begin
      bus4.wr_en   = 1'b1;
      bus4.wr_addr = 2'd0;
      bus4.wr_data = 8'd0;
    end
    @(negedge clk);
    busyAtK         = bus4.busy;
    bus4.start_sort = 1'b0;
    bus4.wr_en      = 1'b0;
    edges = 0;
    dones = 0;
    while (bus4.done !== 1'b1 && edges < 200) begin
      if (edges == injectAt) begin
        bus4.start_sort = 1'b1;
        bus4.wr_en      = 1'b1;
        bus4.wr_addr    = 2'd0;
        bus4.wr_data    = 8'hFF;
      end
      if (toggleDir) bus4.descend = ~bus4.descend;
      @(negedge clk);
      edges++;
      bus4.start_sort = 1'b0;
      bus4.wr_en      = 1'b0;
    end
    if (bus4.done === 1'b1) dones = 1;
    repeat (12) begin
      @(negedge clk);
      if (bus4.done === 1'b1) dones++;
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    idleInputs();
    rst4  = 1'b0;
    rst16 = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (bus4.busy !== 1'b0 || bus4.done !== 1'b0 || bus4.swap_count !== 4'd0) begin
      bad++;
      $display("[TB] FAIL reset4_status: busy=%b done=%b swaps=%0d, required 0/0/0",
               bus4.busy, bus4.done, bus4.swap_count);
    end
    total++;
    if (bus16.busy !== 1'b0 || bus16.done !== 1'b0 || bus16.swap_count !== 8'd0) begin
      bad++;
      $display("[TB] FAIL reset16_status: busy=%b done=%b swaps=%0d, required 0/0/0",
               bus16.busy, bus16.done, bus16.swap_count);
    end
    rst4  = 1'b1;
    rst16 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      read4(i, d);
      total++;
      if (d !== 8'd0) begin
        bad++;
        $display("[TB] FAIL reset4_mem[%0d]: got %0d, required 0", i, d);
      end
    end
    for (int i = 0; i < 16; i++) begin
      read16(i, d);
      total++;
      if (d !== 8'd0) begin
        bad++;
        $display("[TB] FAIL reset16_mem[%0d]: got %0d, required 0", i, d);
      end
    end
  endtask

  task automatic test_ascend();
    logic [7:0] exp [4];
    logic [7:0] d;
    int edges, dones;
    logic busyK;
    exp[0] = 8'd1; exp[1] = 8'd2; exp[2] = 8'd3; exp[3] = 8'd4;
    load4(8'd3, 8'd1, 8'd4, 8'd2);
    sort4(1'b0, 1'b0, -1, 1'b0, edges, dones, busyK);
    total++;
    if (busyK !== 1'b1) begin
      bad++;
      $display("[TB] FAIL ascend_busy_at_start: got %b, required 1", busyK);
    end
    total++;
    if (edges !== 9) begin
      bad++;
      $display("[TB] FAIL ascend_latency: got %0d edges, required 9", edges);
    end
    total++;
    if (dones !== 1) begin
      bad++;
      $display("[TB] FAIL ascend_done_pulses: got %0d, required 1", dones);
    end
    total++;
    if (bus4.swap_count !== 4'd3 || bus4.busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL ascend_swaps_idle: swaps=%0d busy=%b, required 3/0",
               bus4.swap_count, bus4.busy);
    end
    for (int i = 0; i < 4; i++) begin
      read4(i, d);
      total++;
      if (d !== exp[i]) begin
        bad++;
        $display("[TB] FAIL ascend_mem[%0d]: got %0d, required %0d", i, d, exp[i]);
      end
    end
  endtask

  task automatic test_descend_toggle();
    logic [7:0] exp [4];
    logic [7:0] d;
    int edges, dones;
    logic busyK;
    exp[0] = 8'd4; exp[1] = 8'd3; exp[2] = 8'd2; exp[3] = 8'd1;
    load4(8'd3, 8'd1, 8'd4, 8'd2);
    sort4(1'b1, 1'b1, -1, 1'b0, edges, dones, busyK);
    total++;
    if (edges !== 9 || dones !== 1) begin
      bad++;
      $display("[TB] FAIL descend_timing: edges=%0d dones=%0d, required 9/1", edges, dones);
    end
    total++;
    if (bus4.swap_count !== 4'd3) begin
      bad++;
      $display("[TB] FAIL descend_swaps: got %0d, required 3", bus4.swap_count);
    end
    for (int i = 0; i < 4; i++) begin
      read4(i, d);
      total++;
      if (d !== exp[i]) begin
        bad++;
        $display("[TB] FAIL descend_mem[%0d]: got %0d, required %0d", i, d, exp[i]);
      end
    end
  endtask

  task automatic test_duplicates();
    logic [7:0] exp [4];
    logic [7:0] d;
    int edges, dones;
    logic busyK;
    exp[0] = 8'd2; exp[1] = 8'd5; exp[2] = 8'd5; exp[3] = 8'd5;
    load4(8'd5, 8'd5, 8'd2, 8'd5);
    sort4(1'b0, 1'b0, -1, 1'b0, edges, dones, busyK);
    total++;
    if (bus4.swap_count !== 4'd2 || edges !== 9) begin
      bad++;
      $display("[TB] FAIL dup_swaps_latency: swaps=%0d edges=%0d, required 2/9",
               bus4.swap_count, edges);
    end
    for (int i = 0; i < 4; i++) begin
      read4(i, d);
      total++;
      if (d !== exp[i]) begin
        bad++;
        $display("[TB] FAIL dup_mem[%0d]: got %0d, required %0d", i, d, exp[i]);
      end
    end
  endtask

  task automatic test_sorted_input();
    logic [7:0] d;
    int edges, dones;
    logic busyK;
    load4(8'd1, 8'd2, 8'd3, 8'd4);
    sort4(1'b0, 1'b0, -1, 1'b0, edges, dones, busyK);
    total++;
    if (edges !== EXP_SORTED_EDGES || dones !== 1) begin
      bad++;
      $display("[TB] FAIL sorted_latency: edges=%0d dones=%0d, required %0d/1",
               edges, dones, EXP_SORTED_EDGES);
    end
    total++;
    if (bus4.swap_count !== 4'd0) begin
      bad++;
      $display("[TB] FAIL sorted_swaps: got %0d, required 0", bus4.swap_count);
    end
    for (int i = 0; i < 4; i++) begin
      read4(i, d);
      total++;
      if (d !== 8'(i + 1)) begin
        bad++;
        $display("[TB] FAIL sorted_mem[%0d]: got %0d, required %0d", i, d, i + 1);
      end
    end
  endtask

  task automatic test_ignore_while_busy();
    logic [7:0] exp [4];
    logic [7:0] d;
    int edges, dones;
    logic busyK;
    exp[0] = 8'd1; exp[1] = 8'd2; exp[2] = 8'd3; exp[3] = 8'd4;
    load4(8'd3, 8'd1, 8'd4, 8'd2);
    sort4(1'b0, 1'b0, 3, 1'b0, edges, dones, busyK);
    total++;
    if (edges !== 9 || dones !== 1) begin
      bad++;
      $display("[TB] FAIL busy_ignore_timing: edges=%0d dones=%0d, required 9/1", edges, dones);
    end
    total++;
    if (bus4.swap_count !== 4'd3) begin
      bad++;
      $display("[TB] FAIL busy_ignore_swaps: got %0d, required 3", bus4.swap_count);
    end
    for (int i = 0; i < 4; i++) begin
      read4(i, d);
      total++;
      if (d !== exp[i]) begin
        bad++;
        $display("[TB] FAIL busy_ignore_mem[%0d]: got %0d, required %0d", i, d, exp[i]);
      end
    end
  endtask

  task automatic test_write_with_start();
    logic [7:0] exp [4];
    logic [7:0] d;
    int edges, dones;
    logic busyK;
    exp[0] = 8'd0; exp[1] = 8'd1; exp[2] = 8'd2; exp[3] = 8'd4;
    load4(8'd3, 8'd1, 8'd4, 8'd2);
    sort4(1'b0, 1'b0, -1, 1'b1, edges, dones, busyK);
    total++;
    if (edges !== EXP_PREWR_EDGES || bus4.swap_count !== 4'd1) begin
      bad++;
      $display("[TB] FAIL prewrite_latency_swaps: edges=%0d swaps=%0d, required %0d/1",
               edges, bus4.swap_count, EXP_PREWR_EDGES);
    end
    for (int i = 0; i < 4; i++) begin
      read4(i, d);
      total++;
      if (d !== exp[i]) begin
        bad++;
        $display("[TB] FAIL prewrite_mem[%0d]: got %0d, required %0d", i, d, exp[i]);
      end
    end
  endtask

  task automatic load16Reverse();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus16.wr_en   = 1'b1;
      bus16.wr_addr = 4'(i);
      bus16.wr_data = 8'(15 - i);
    end
    @(negedge clk);
    bus16.wr_en = 1'b0;
  endtask

  task automatic test_depth16();
    logic [7:0] d;
    int edges;
    load16Reverse();
    @(negedge clk);
    bus16.start_sort = 1'b1;
    bus16.descend    = 1'b0;
    @(negedge clk);
    bus16.start_sort = 1'b0;
    edges = 0;
    while (bus16.done !== 1'b1 && edges < 400) begin
      @(negedge clk);
      edges++;
    end
    total++;
    if (edges !== 135) begin
      bad++;
      $display("[TB] FAIL d16_latency: got %0d edges, required 135", edges);
    end
    total++;
    if (bus16.swap_count !== 8'd120) begin
      bad++;
      $display("[TB] FAIL d16_swaps: got %0d, required 120", bus16.swap_count);
    end
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      read16(i, d);
      total++;
      if (d !== 8'(i)) begin
        bad++;
        $display("[TB] FAIL d16_mem[%0d]: got %0d, required %0d", i, d, i);
      end
    end
  endtask

  task automatic test_reset_mid_sort();
    logic [7:0] d;
    int dones;
    load16Reverse();
    @(negedge clk);
    bus16.start_sort = 1'b1;
    @(negedge clk);
    bus16.start_sort = 1'b0;
    repeat (50) @(negedge clk);
    total++;
    if (bus16.busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL midreset_busy_before: got %b, required 1", bus16.busy);
    end
    rst16 = 1'b0;
    #1;
    total++;
    if (bus16.busy !== 1'b0 || bus16.done !== 1'b0 || bus16.swap_count !== 8'd0) begin
      bad++;
      $display("[TB] FAIL midreset_status: busy=%b done=%b swaps=%0d, required 0/0/0",
               bus16.busy, bus16.done, bus16.swap_count);
    end
    @(negedge clk);
    rst16 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      read16(i, d);
      total++;
      if (d !== 8'd0) begin
        bad++;
        $display("[TB] FAIL midreset_mem[%0d]: got %0d, required 0", i, d);
      end
    end
    dones = 0;
    repeat (150) begin
      @(negedge clk);
      if (bus16.done === 1'b1) dones++;
    end
    total++;
    if (dones !== 0) begin
      bad++;
      $display("[TB] FAIL midreset_no_done: got %0d done cycles, required 0", dones);
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    test_reset();
    test_ascend();
    test_descend_toggle();
    test_duplicates();
    test_sorted_input();
    test_ignore_while_busy();
    test_write_with_start();
    test_depth16();
    test_reset_mid_sort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
